// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and constants for the data-RAM access arbiter.
package ram_access_arbiter_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LOCK_CNT_W = 4;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_t;

    // Index width for a requester vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_rr_pick.sv
// Combinational winner selection: fixed-priority high-priority masters first,
// otherwise round-robin starting just after the pointer.
module ram_access_arbiter_rr_pick #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [NUM_MASTERS-1:0] i_hipri,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic                   o_valid,
    output logic [IDX_W-1:0]       o_idx
);

    logic [NUM_MASTERS-1:0] w_hi_req;

    assign w_hi_req = i_req & i_hipri;
    assign o_valid  = |i_req;

    // Scan far-to-near so the last hit (the nearest candidate) is the one kept.
    always_comb begin
        int c;
        c     = 0;
        o_idx = '0;
        if (|w_hi_req) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (w_hi_req[i]) o_idx = IDX_W'(i);
            end
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                c = int'(i_ptr) + k;
                if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
                if (i_req[c]) o_idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Serialises NUM_MASTERS requesters onto one single-port data RAM, gating
// writes with the PMP verdict and returning read data with a one-cycle ack.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int                     NUM_MASTERS = 3,
    parameter logic [NUM_MASTERS-1:0] HIPRI_MASK  = '0,
    parameter int                     LOCK_MAX    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_lock_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
    output logic [DATA_W-1:0]             m_data_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic                          ram_req_o,
    output logic                          ram_we_o,
    output logic [ADDR_W-1:0]             ram_addr_o,
    output logic [DATA_W-1:0]             ram_data_o,
    input  logic [DATA_W-1:0]             ram_data_i,
    input  logic                          pmp_fault_i
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX - 1);

    arb_state_t               r_state;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_we;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [DATA_W-1:0]        r_rdata;
    logic [NUM_MASTERS-1:0]   r_ack;
    logic [NUM_MASTERS-1:0]   r_err;
    logic [IDX_W-1:0]         r_ptr;
    logic                     r_lock_vld;
    logic [IDX_W-1:0]         r_lock_idx;
    logic [LOCK_CNT_W-1:0]    r_lock_cnt;

    logic                     w_pick_vld;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_lock_hit;
    logic [IDX_W-1:0]         w_win_idx;
    logic [NUM_MASTERS-1:0]   w_idx_onehot;
    logic                     w_access;

    ram_access_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .i_req   (m_req_i),
        .i_hipri (HIPRI_MASK),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    // A requesting lock owner overrides every other priority rule.
    assign w_lock_hit   = r_lock_vld & m_req_i[r_lock_idx];
    assign w_win_idx    = w_lock_hit ? r_lock_idx : w_pick_idx;
    assign w_idx_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_idx;

    // RAM strobes are decoded from state so a reset aborts a write immediately.
    assign w_access   = (r_state == ARB_ACCESS);
    assign ram_req_o  = w_access;
    assign ram_we_o   = w_access & r_we & ~pmp_fault_i;
    assign ram_addr_o = w_access ? r_addr  : '0;
    assign ram_data_o = w_access ? r_wdata : ZERO_WORD;

    assign m_ack_o  = r_ack;
    assign m_err_o  = r_err;
    assign m_data_o = r_rdata;

    // Transaction FSM: arbitrate, access the RAM, respond; plus lock bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= ZERO_WORD;
            r_rdata    <= ZERO_WORD;
            r_ack      <= '0;
            r_err      <= '0;
            r_ptr      <= IDX_W'(NUM_MASTERS - 1);
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (r_lock_vld && !m_req_i[r_lock_idx]) begin
                        r_lock_vld <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                    if (w_pick_vld) begin
                        r_idx   <= w_win_idx;
                        r_we    <= m_we_i[w_win_idx];
                        r_addr  <= m_addr_i[ADDR_W*w_win_idx +: ADDR_W];
                        r_wdata <= m_data_i[DATA_W*w_win_idx +: DATA_W];
                        r_state <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    r_ack   <= w_idx_onehot;
                    r_err   <= pmp_fault_i ? w_idx_onehot : '0;
                    r_rdata <= (r_we | pmp_fault_i) ? ZERO_WORD : ram_data_i;
                    r_state <= ARB_RESP;
                end
                ARB_RESP: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_rdata <= ZERO_WORD;
                    r_ptr   <= r_idx;
                    if (m_lock_i[r_idx] && (r_lock_cnt < LOCK_LIMIT)) begin
                        r_lock_vld <= 1'b1;
                        r_lock_idx <= r_idx;
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end else begin
                        r_lock_vld <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a behavioural RAM on the main
// instance, plus a second instance with master 2 marked high priority.
module tb_ram_access_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req, m_we, m_lock;
    logic [95:0] m_addr, m_data;
    logic [31:0] rd_data;
    logic [2:0]  m_ack, m_err;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        pmp;

    logic [2:0]  h_req;
    logic [31:0] h_rd_data;
    logic [2:0]  h_ack, h_err;
    logic        h_ram_req, h_ram_we;
    logic [31:0] h_ram_addr, h_ram_wdata;

    logic [31:0] mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [31:0] ld_data;

    int n_cmp;
    int n_fail;

    ram_access_arbiter #(.NUM_MASTERS(3), .HIPRI_MASK(3'b000), .LOCK_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_lock_i(m_lock),
        .m_addr_i(m_addr), .m_data_i(m_data), .m_data_o(rd_data), .m_ack_o(m_ack),
        .m_err_o(m_err), .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata), .pmp_fault_i(pmp)
    );

    ram_access_arbiter #(.NUM_MASTERS(3), .HIPRI_MASK(3'b100), .LOCK_MAX(4)) u_hip (
        .clk(clk), .rst(rst), .m_req_i(h_req), .m_we_i(3'b000), .m_lock_i(3'b000),
        .m_addr_i(m_addr), .m_data_i(m_data), .m_data_o(h_rd_data), .m_ack_o(h_ack),
        .m_err_o(h_err), .ram_req_o(h_ram_req), .ram_we_o(h_ram_we), .ram_addr_o(h_ram_addr),
        .ram_data_o(h_ram_wdata), .ram_data_i(32'h0), .pmp_fault_i(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: combinational read, write on the clock edge.
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ram_load(input logic [31:0] addr, input logic [31:0] data);
        ld_en = 1'b1; ld_idx = addr[9:2]; ld_data = data;
        tick;
        ld_en = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        m_req = 3'b010; m_we = 3'b010;
        m_addr[32+:32] = 32'h300; m_data[32+:32] = 32'hCAFE0001;
        tick;
        n_cmp++;
        if ({ram_req, ram_we} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_access got %b want 11", {ram_req, ram_we});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_req, ram_we, ram_addr, ram_wdata, m_ack, m_err, rd_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs req=%b we=%b addr=%h ack=%b err=%b data=%h want all 0",
                               ram_req, ram_we, ram_addr, m_ack, m_err, rd_data);
        end
        tick;
        n_cmp++;
        if (mem[8'hC0] !== 32'h11110000) begin
            n_fail++; $display("FAIL reset_no_write got %h want 11110000", mem[8'hC0]);
        end
        n_cmp++;
        if (m_ack !== 3'b000) begin
            n_fail++; $display("FAIL reset_no_ack got %b want 000", m_ack);
        end
        rst = 1'b0; m_we = 3'b000;
        tick;
        n_cmp++;
        if (m_ack !== 3'b000) begin
            n_fail++; $display("FAIL reset_cycle1_ack got %b want 000", m_ack);
        end
        tick;
        n_cmp++;
        if (m_ack !== 3'b010 || rd_data !== 32'h11110000) begin
            n_fail++; $display("FAIL reset_first_ack got ack=%b data=%h want 010/11110000", m_ack, rd_data);
        end
        m_req = 3'b000;
        tick;
    endtask

    task automatic test_single_read;
        m_req = 3'b001; m_we = 3'b000; m_addr[0+:32] = 32'h100;
        tick;
        n_cmp++;
        if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h100) begin
            n_fail++; $display("FAIL read_access got req=%b we=%b addr=%h want 1/0/100", ram_req, ram_we, ram_addr);
        end
        tick;
        n_cmp++;
        if (m_ack !== 3'b001 || m_err !== 3'b000 || rd_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_resp got ack=%b err=%b data=%h want 001/000/deadbeef", m_ack, m_err, rd_data);
        end
        m_req = 3'b000;
        tick;
        n_cmp++;
        if (m_ack !== 3'b000 || rd_data !== 32'h0 || ram_req !== 1'b0) begin
            n_fail++; $display("FAIL read_idle got ack=%b data=%h req=%b want 000/0/0", m_ack, rd_data, ram_req);
        end
    endtask

    task automatic test_drop_req;
        m_req = 3'b001; m_we = 3'b000; m_addr[0+:32] = 32'h100;
        tick;
        m_req = 3'b000;
        tick;
        n_cmp++;
        if (m_ack !== 3'b001 || rd_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL drop_ack got ack=%b data=%h want 001/deadbeef", m_ack, rd_data);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_d [0:2];
        logic [2:0]  exp_a;
        exp_d[0] = 32'hDEADBEEF; exp_d[1] = 32'h000000B1; exp_d[2] = 32'h000000B2;
        m_addr = {32'h108, 32'h104, 32'h100};
        m_we = 3'b000; m_req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_a = 3'b001 << (i % 3);
            tick;
            tick;
            n_cmp++;
            if (m_ack !== exp_a || rd_data !== exp_d[i % 3]) begin
                n_fail++; $display("FAIL rr_grant%0d got ack=%b data=%h want %b/%h", i, m_ack, rd_data, exp_a, exp_d[i % 3]);
            end
            if (i == 5) m_req = 3'b000;
            tick;
        end
    endtask

    task automatic test_lock;
        logic [2:0] exp_a;
        m_we = 3'b000; m_lock = 3'b010; m_req = 3'b010;
        for (int i = 0; i < 5; i++) begin
            exp_a = (i < 4) ? 3'b010 : 3'b001;
            tick;
            m_req = 3'b011;
            tick;
            n_cmp++;
            if (m_ack !== exp_a) begin
                n_fail++; $display("FAIL lock_grant%0d got ack=%b want %b", i, m_ack, exp_a);
            end
            if (i == 4) begin m_req = 3'b000; m_lock = 3'b000; end
            tick;
        end
    endtask

    task automatic test_write;
        m_req = 3'b100; m_we = 3'b100;
        m_addr[64+:32] = 32'h204; m_data[64+:32] = 32'h0000A5A5;
        tick;
        n_cmp++;
        if (ram_we !== 1'b1 || ram_wdata !== 32'h0000A5A5 || ram_addr !== 32'h204) begin
            n_fail++; $display("FAIL write_access got we=%b data=%h addr=%h want 1/a5a5/204", ram_we, ram_wdata, ram_addr);
        end
        tick;
        n_cmp++;
        if (m_ack !== 3'b100 || m_err !== 3'b000 || rd_data !== 32'h0 || mem[8'h81] !== 32'h0000A5A5) begin
            n_fail++; $display("FAIL write_resp got ack=%b err=%b data=%h mem=%h want 100/000/0/a5a5",
                               m_ack, m_err, rd_data, mem[8'h81]);
        end
        m_req = 3'b000; m_we = 3'b000;
        tick;
    endtask

    task automatic test_pmp;
        m_req = 3'b001; m_we = 3'b001; pmp = 1'b1;
        m_addr[0+:32] = 32'h200; m_data[0+:32] = 32'h55;
        tick;
        n_cmp++;
        if (ram_req !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL pmp_we_gated got req=%b we=%b want 1/0", ram_req, ram_we);
        end
        pmp = 1'b0; #1;
        n_cmp++;
        if (ram_we !== 1'b1) begin
            n_fail++; $display("FAIL pmp_we_open got %b want 1", ram_we);
        end
        pmp = 1'b1; #1;
        tick;
        n_cmp++;
        if (m_ack !== 3'b001 || m_err !== 3'b001 || rd_data !== 32'h0) begin
            n_fail++; $display("FAIL pmp_write_resp got ack=%b err=%b data=%h want 001/001/0", m_ack, m_err, rd_data);
        end
        m_req = 3'b000; m_we = 3'b000;
        tick;
        n_cmp++;
        if (mem[8'h80] !== 32'h12345678 || m_err !== 3'b000) begin
            n_fail++; $display("FAIL pmp_ram_unchanged got mem=%h err=%b want 12345678/000", mem[8'h80], m_err);
        end
        m_req = 3'b010; m_addr[32+:32] = 32'h100;
        tick;
        tick;
        n_cmp++;
        if (m_ack !== 3'b010 || m_err !== 3'b010 || rd_data !== 32'h0) begin
            n_fail++; $display("FAIL pmp_read_resp got ack=%b err=%b data=%h want 010/010/0", m_ack, m_err, rd_data);
        end
        m_req = 3'b000; pmp = 1'b0;
        tick;
    endtask

    task automatic test_hipri;
        h_req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick;
            tick;
            n_cmp++;
            if (h_ack !== 3'b100) begin
                n_fail++; $display("FAIL hipri_grant%0d got ack=%b want 100", i, h_ack);
            end
            if (i == 3) h_req = 3'b011;
            tick;
        end
        tick;
        tick;
        n_cmp++;
        if (h_ack !== 3'b001) begin
            n_fail++; $display("FAIL hipri_fallback got ack=%b want 001", h_ack);
        end
        h_req = 3'b000;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; pmp = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        m_req = '0; m_we = '0; m_lock = '0; m_addr = '0; m_data = '0; h_req = '0;
        ram_load(32'h100, 32'hDEADBEEF);
        ram_load(32'h104, 32'h000000B1);
        ram_load(32'h108, 32'h000000B2);
        ram_load(32'h200, 32'h12345678);
        ram_load(32'h300, 32'h11110000);
        rst = 1'b0;
        tick;
        test_reset;
        test_single_read;
        test_drop_req;
        do_reset;
        test_round_robin;
        do_reset;
        test_lock;
        test_write;
        test_pmp;
        do_reset;
        test_hipri;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
